// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
//
// Single-clock AXI-Stream FIFO. Buffers DEPTH words of {tlast, tdata} between
// a stream master (s_*) and a stream slave (m_*), and reports how many words
// are held. All outputs are registers, so there is no combinational path from
// s_tvalid to s_tready or from m_tready to m_tvalid.
//
// Optional feature macro: AXIS_FIFO_PKT_MODE_EN
//   Defined   : store-and-forward. The head word is offered only while at
//               least one complete frame (a stored word with tlast=1) is
//               buffered, or while the FIFO is full. Releasing on full stops
//               a frame larger than DEPTH from deadlocking the FIFO.
//   Undefined : cut-through. The head word is offered whenever the FIFO is
//               not empty, and tlast is simply passed through.
//
// Parameters
//   DATA_W : tdata width
//   DEPTH  : number of entries, power of two, minimum 2
//   CNT_W  : width of count (derived, not overridable)
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : synchronous active-low reset
//   s_tdata  : upstream data
//   s_tvalid : upstream data valid
//   s_tlast  : upstream end-of-packet marker
//   s_tready : FIFO can accept a word (registered)
//   m_tdata  : head-of-FIFO data (registered)
//   m_tvalid : head word available (registered)
//   m_tlast  : tlast stored with the head word (registered)
//   m_tready : downstream accepts the head word
//   count    : words currently stored, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module axis_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Storage: bit DATA_W holds tlast, the rest holds tdata.
  logic [DATA_W:0]      mem_r [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [PTR_W-1:0]     wr_ptr_nxt_s;
  logic [PTR_W-1:0]     rd_ptr_nxt_s;

  logic                 push_s;
  logic                 pop_s;
  logic                 empty_nxt_s;
  logic                 full_nxt_s;
  logic                 valid_nxt_s;
  logic [CNT_W-1:0]     count_nxt_s;
  logic [DATA_W:0]      head_nxt_s;

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [CNT_W-1:0]     pkt_cnt_r;
  logic [CNT_W-1:0]     pkt_cnt_nxt_s;
`endif

  // Handshakes, next-state pointers and occupancy.
  always_comb begin
    push_s = s_tvalid && s_tready;
    pop_s  = m_tvalid && m_tready;

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count + CNT_W'(1);
      2'b01:   count_nxt_s = count - CNT_W'(1);
      default: count_nxt_s = count;
    endcase

    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                  (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
  end

  // Next head word. When the slot that becomes the head is the one being
  // written this cycle (the FIFO is draining to empty or is already empty),
  // the array still holds stale data, so take the incoming word instead.
  always_comb begin
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = {s_tlast, s_tdata};
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  // Count of stored complete frames and the store-and-forward release rule.
  always_comb begin
    case ({push_s && s_tlast, pop_s && m_tlast})
      2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + CNT_W'(1);
      2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - CNT_W'(1);
      default: pkt_cnt_nxt_s = pkt_cnt_r;
    endcase
    valid_nxt_s = !empty_nxt_s && ((pkt_cnt_nxt_s != CNT_W'(0)) || full_nxt_s);
  end
`else
  // Cut-through release rule: any stored word is offered.
  always_comb begin
    valid_nxt_s = !empty_nxt_s;
  end
`endif

  // Storage array write port; contents are not cleared by reset because the
  // pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  // Pointers, occupancy and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count    <= CNT_W'(0);
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= DATA_W'(0);
      m_tlast  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count    <= count_nxt_s;
      s_tready <= !full_nxt_s;
      m_tvalid <= valid_nxt_s;
      m_tdata  <= head_nxt_s[DATA_W-1:0];
      m_tlast  <= head_nxt_s[DATA_W];
    end
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  // Complete-frame counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt_r <= CNT_W'(0);
    end else begin
      pkt_cnt_r <= pkt_cnt_nxt_s;
    end
  end
`endif

endmodule
